mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 199 +++++++++++++++++++
 tb/tb_mem_stage.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage sitting behind the EX/MEM register.
//
// Performs word loads (LDW) and stores (STW) on the CPU bus using an
// active-low ready handshake. Misaligned accesses are not issued; they
// are turned into a MISS_ALIGN exception. busy tells the pipeline
// controller that a strobe is out and not yet acknowledged. The block
// also owns the MEM/WB pipeline register.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ex_*                EX/MEM register fields (pc, valid, branch flag, memory op,
//                       store data, ctrl op, dest reg, GPR we_ (active-low),
//                       exception code, ALU result / byte address)
//   stall, flush        controller stall (includes busy) and flush
//   busy                access in progress, not yet acknowledged
//   bus_as_, bus_rw     address strobe (active-low), 1 = read / 0 = write
//   bus_addr            word address
//   bus_wr_data         store data
//   bus_rd_data         load data, valid while bus_rdy_ = 0
//   bus_rdy_            transfer acknowledge, active-low
//   mem_*               MEM/WB register outputs
module mem_stage #(
   parameter int unsigned WORD_DATA_W = 32,
   parameter int unsigned WORD_ADDR_W = 30
) (
   input  logic                   clk,
   input  logic                   reset,
   // EX/MEM register
   input  logic [WORD_ADDR_W-1:0] ex_pc,
   input  logic                   ex_en,
   input  logic                   ex_br_flag,
   input  logic [1:0]             ex_mem_op,
   input  logic [WORD_DATA_W-1:0] ex_mem_wr_data,
   input  logic [1:0]             ex_ctrl_op,
   input  logic [4:0]             ex_dst_addr,
   input  logic                   ex_gpr_we_,
   input  logic [2:0]             ex_exp_code,
   input  logic [WORD_DATA_W-1:0] ex_out,
   // pipeline control
   input  logic                   stall,
   input  logic                   flush,
   output logic                   busy,
   // CPU bus
   output logic                   bus_as_,
   output logic                   bus_rw,
   output logic [WORD_ADDR_W-1:0] bus_addr,
   output logic [WORD_DATA_W-1:0] bus_wr_data,
   input  logic [WORD_DATA_W-1:0] bus_rd_data,
   input  logic                   bus_rdy_,
   // MEM/WB register
   output logic [WORD_ADDR_W-1:0] mem_pc,
   output logic                   mem_en,
   output logic                   mem_br_flag,
   output logic [1:0]             mem_ctrl_op,
   output logic [4:0]             mem_dst_addr,
   output logic                   mem_gpr_we_,
   output logic [2:0]             mem_exp_code,
   output logic [WORD_DATA_W-1:0] mem_out
);

   localparam logic [1:0] MemOpLdw  = 2'd1;
   localparam logic [1:0] MemOpStw  = 2'd2;
   localparam logic [2:0] ExpNone   = 3'd0;
   localparam logic [2:0] ExpMisAln = 3'd4;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StStall
   } state_t;

   state_t                 state_q, state_d;
   logic [WORD_DATA_W-1:0] rd_buf_q, rd_buf_d;

   logic                   acc_valid;
   logic                   misalign;
   logic                   go;
   logic                   strobe;
   logic [WORD_DATA_W-1:0] load_data;
   logic [WORD_DATA_W-1:0] result;

   // ------------------------------------------------------------------
   // Access decode
   // ------------------------------------------------------------------
   always_comb begin
      acc_valid = ex_en && (ex_exp_code == ExpNone) &&
                  ((ex_mem_op == MemOpLdw) || (ex_mem_op == MemOpStw));
      misalign  = acc_valid && (ex_out[1:0] != 2'b00);
      go        = acc_valid && !misalign;
   end

   // ------------------------------------------------------------------
   // Bus outputs: strobe is raised in the same cycle the access arrives
   // so a zero-wait slave completes it without ever asserting busy.
   // ------------------------------------------------------------------
   always_comb begin
      strobe      = ((state_q == StIdle) && go) || (state_q == StAccess);
      bus_as_     = 1'b1;
      bus_rw      = 1'b1;
      bus_addr    = '0;
      bus_wr_data = '0;
      if (strobe) begin
         bus_as_     = 1'b0;
         bus_rw      = (ex_mem_op == MemOpLdw);
         bus_addr    = ex_out[WORD_DATA_W-1:2];
         bus_wr_data = ex_mem_wr_data;
      end
      busy = strobe && bus_rdy_;
   end

   // ------------------------------------------------------------------
   // Access FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      rd_buf_d = rd_buf_q;
      unique case (state_q)
         StIdle: begin
            if (go) begin
               if (!bus_rdy_) begin
                  rd_buf_d = bus_rd_data;
                  state_d  = stall ? StStall : StIdle;
               end else begin
                  state_d = StAccess;
               end
            end
         end
         StAccess: begin
            if (!bus_rdy_) begin
               rd_buf_d = bus_rd_data;
               state_d  = stall ? StStall : StIdle;
            end
         end
         StStall: begin
            // Access already done; wait out the stall without re-issuing.
            if (!stall) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         rd_buf_q <= '0;
      end else begin
         state_q  <= state_d;
         rd_buf_q <= rd_buf_d;
      end
   end

   // ------------------------------------------------------------------
   // Result selection
   // ------------------------------------------------------------------
   always_comb begin
      load_data = (state_q == StStall) ? rd_buf_q : bus_rd_data;
      unique case (ex_mem_op)
         MemOpLdw: result = load_data;
         MemOpStw: result = '0;
         default:  result = ex_out;
      endcase
   end

   // ------------------------------------------------------------------
   // MEM/WB register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset || (!stall && flush)) begin
         mem_pc       <= '0;
         mem_en       <= 1'b0;
         mem_br_flag  <= 1'b0;
         mem_ctrl_op  <= 2'd0;
         mem_dst_addr <= 5'd0;
         mem_gpr_we_  <= 1'b1;
         mem_exp_code <= ExpNone;
         mem_out      <= '0;
      end else if (!stall) begin
         mem_pc      <= ex_pc;
         mem_en      <= ex_en;
         mem_br_flag <= ex_br_flag;
         if (misalign) begin
            mem_ctrl_op  <= 2'd0;
            mem_dst_addr <= 5'd0;
            mem_gpr_we_  <= 1'b1;
            mem_exp_code <= ExpMisAln;
            mem_out      <= '0;
         end else begin
            mem_ctrl_op  <= ex_ctrl_op;
            mem_dst_addr <= ex_dst_addr;
            mem_gpr_we_  <= ex_gpr_we_;
            mem_exp_code <= ex_exp_code;
            mem_out      <= result;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Inputs change 1 time unit after the rising edge; combinational outputs
// are sampled 2 units later, registered outputs 1 unit after the next edge.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [29:0] ex_pc;
   logic        ex_en;
   logic        ex_br_flag;
   logic [1:0]  ex_mem_op;
   logic [31:0] ex_mem_wr_data;
   logic [1:0]  ex_ctrl_op;
   logic [4:0]  ex_dst_addr;
   logic        ex_gpr_we_;
   logic [2:0]  ex_exp_code;
   logic [31:0] ex_out;
   logic        stall;
   logic        ext_stall;
   logic        flush;
   logic        busy;
   logic        bus_as_;
   logic        bus_rw;
   logic [29:0] bus_addr;
   logic [31:0] bus_wr_data;
   logic [31:0] bus_rd_data;
   logic        bus_rdy_;
   logic [29:0] mem_pc;
   logic        mem_en;
   logic        mem_br_flag;
   logic [1:0]  mem_ctrl_op;
   logic [4:0]  mem_dst_addr;
   logic        mem_gpr_we_;
   logic [2:0]  mem_exp_code;
   logic [31:0] mem_out;

   int vec = 0;
   int err = 0;

   // Controller model: stall includes this block's busy.
   assign stall = busy | ext_stall;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk            (clk),
      .reset          (reset),
      .ex_pc          (ex_pc),
      .ex_en          (ex_en),
      .ex_br_flag     (ex_br_flag),
      .ex_mem_op      (ex_mem_op),
      .ex_mem_wr_data (ex_mem_wr_data),
      .ex_ctrl_op     (ex_ctrl_op),
      .ex_dst_addr    (ex_dst_addr),
      .ex_gpr_we_     (ex_gpr_we_),
      .ex_exp_code    (ex_exp_code),
      .ex_out         (ex_out),
      .stall          (stall),
      .flush          (flush),
      .busy           (busy),
      .bus_as_        (bus_as_),
      .bus_rw         (bus_rw),
      .bus_addr       (bus_addr),
      .bus_wr_data    (bus_wr_data),
      .bus_rd_data    (bus_rd_data),
      .bus_rdy_       (bus_rdy_),
      .mem_pc         (mem_pc),
      .mem_en         (mem_en),
      .mem_br_flag    (mem_br_flag),
      .mem_ctrl_op    (mem_ctrl_op),
      .mem_dst_addr   (mem_dst_addr),
      .mem_gpr_we_    (mem_gpr_we_),
      .mem_exp_code   (mem_exp_code),
      .mem_out        (mem_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ex_idle();
      ex_pc          = '0;
      ex_en          = 1'b0;
      ex_br_flag     = 1'b0;
      ex_mem_op      = 2'd0;
      ex_mem_wr_data = '0;
      ex_ctrl_op     = 2'd0;
      ex_dst_addr    = 5'd0;
      ex_gpr_we_     = 1'b1;
      ex_exp_code    = 3'd0;
      ex_out         = '0;
   endtask

   task automatic ex_set(input logic [29:0] pc, input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] dst, input logic we_);
      ex_pc          = pc;
      ex_en          = 1'b1;
      ex_mem_op      = op;
      ex_out         = addr;
      ex_mem_wr_data = wdata;
      ex_dst_addr    = dst;
      ex_gpr_we_     = we_;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ex_idle();
      tick();
      tick();
      vec++; if (bus_as_ !== 1'b1) begin $display("FAIL reset_as: got %b want 1", bus_as_); err++; end
      vec++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); err++; end
      vec++; if (bus_rw !== 1'b1 || bus_addr !== 30'd0 || bus_wr_data !== 32'd0) begin
         $display("FAIL reset_bus: got rw=%b addr=%h wd=%h want 1/0/0", bus_rw, bus_addr, bus_wr_data);
         err++;
      end
      vec++; if ({mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code,
                  mem_out} !== {30'd0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'd0}) begin
         $display("FAIL reset_memwb: got pc=%h en=%b we_=%b exp=%0d out=%h want 0/0/1/0/0",
                  mem_pc, mem_en, mem_gpr_we_, mem_exp_code, mem_out);
         err++;
      end
      reset = 1'b0;
   endtask

   task automatic test_ldw_zero_wait();
      ex_set(30'h10, 2'd1, 32'h0000_0104, 32'h0, 5'd5, 1'b0);
      bus_rdy_    = 1'b0;
      bus_rd_data = 32'hDEAD_BEEF;
      #2;
      vec++; if (bus_as_ !== 1'b0 || bus_addr !== 30'h41 || bus_rw !== 1'b1) begin
         $display("FAIL ldw0_bus: got as=%b addr=%h rw=%b want 0/41/1", bus_as_, bus_addr, bus_rw);
         err++;
      end
      vec++; if (busy !== 1'b0) begin $display("FAIL ldw0_busy: got %b want 0", busy); err++; end
      tick();
      vec++; if (mem_out !== 32'hDEAD_BEEF) begin
         $display("FAIL ldw0_out: got %h want deadbeef", mem_out); err++;
      end
      vec++; if (mem_gpr_we_ !== 1'b0 || mem_dst_addr !== 5'd5 || mem_pc !== 30'h10 || mem_en !== 1'b1) begin
         $display("FAIL ldw0_fields: got we_=%b dst=%0d pc=%h en=%b want 0/5/10/1",
                  mem_gpr_we_, mem_dst_addr, mem_pc, mem_en);
         err++;
      end
      ex_idle();
      bus_rdy_ = 1'b1;
   endtask

   task automatic test_stw_wait();
      ex_set(30'h14, 2'd2, 32'h0000_0020, 32'h1234_5678, 5'd0, 1'b1);
      bus_rdy_ = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         vec++; if (bus_as_ !== 1'b0 || busy !== 1'b1 || bus_addr !== 30'h8 ||
                    bus_wr_data !== 32'h1234_5678 || bus_rw !== 1'b0) begin
            $display("FAIL stw_wait%0d: got as=%b busy=%b addr=%h wd=%h rw=%b want 0/1/8/12345678/0",
                     i, bus_as_, busy, bus_addr, bus_wr_data, bus_rw);
            err++;
         end
         tick();
         vec++; if (mem_pc !== 30'h10) begin
            $display("FAIL stw_hold%0d: got pc=%h want 10", i, mem_pc); err++;
         end
      end
      bus_rdy_ = 1'b0;
      #2;
      vec++; if (busy !== 1'b0 || bus_as_ !== 1'b0) begin
         $display("FAIL stw_ack: got busy=%b as=%b want 0/0", busy, bus_as_); err++;
      end
      tick();
      vec++; if (mem_out !== 32'd0 || mem_exp_code !== 3'd0 || mem_pc !== 30'h14) begin
         $display("FAIL stw_done: got out=%h exp=%0d pc=%h want 0/0/14", mem_out, mem_exp_code, mem_pc);
         err++;
      end
      ex_idle();
      bus_rdy_ = 1'b1;
   endtask

   task automatic test_misalign();
      ex_set(30'h30, 2'd1, 32'h0000_0102, 32'h0, 5'd9, 1'b0);
      ex_ctrl_op  = 2'd2;
      bus_rdy_    = 1'b0;
      bus_rd_data = 32'h7777_7777;
      #2;
      vec++; if (bus_as_ !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL mis_bus: got as=%b busy=%b want 1/0", bus_as_, busy); err++;
      end
      tick();
      vec++; if (mem_exp_code !== 3'd4 || mem_gpr_we_ !== 1'b1 || mem_ctrl_op !== 2'd0 ||
                 mem_out !== 32'd0 || mem_dst_addr !== 5'd0) begin
         $display("FAIL mis_memwb: got exp=%0d we_=%b ctrl=%0d out=%h dst=%0d want 4/1/0/0/0",
                  mem_exp_code, mem_gpr_we_, mem_ctrl_op, mem_out, mem_dst_addr);
         err++;
      end
      vec++; if (mem_pc !== 30'h30 || mem_en !== 1'b1) begin
         $display("FAIL mis_pass: got pc=%h en=%b want 30/1", mem_pc, mem_en); err++;
      end
      ex_idle();
      bus_rdy_ = 1'b1;
   endtask

   task automatic test_ex_exception_and_nop();
      ex_set(30'h34, 2'd2, 32'h0000_0040, 32'hAAAA_5555, 5'd3, 1'b0);
      ex_exp_code = 3'd2;
      ex_ctrl_op  = 2'd1;
      bus_rdy_    = 1'b1;
      #2;
      vec++; if (bus_as_ !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL exc_bus: got as=%b busy=%b want 1/0", bus_as_, busy); err++;
      end
      tick();
      vec++; if (mem_exp_code !== 3'd2 || mem_ctrl_op !== 2'd1 || mem_dst_addr !== 5'd3) begin
         $display("FAIL exc_pass: got exp=%0d ctrl=%0d dst=%0d want 2/1/3",
                  mem_exp_code, mem_ctrl_op, mem_dst_addr);
         err++;
      end
      ex_idle();
      ex_set(30'h38, 2'd3, 32'hA5A5_0003, 32'h0, 5'd4, 1'b0);
      #2;
      vec++; if (bus_as_ !== 1'b1) begin $display("FAIL nop_bus: got as=%b want 1", bus_as_); err++; end
      tick();
      vec++; if (mem_out !== 32'hA5A5_0003) begin
         $display("FAIL nop_out: got %h want a5a50003", mem_out); err++;
      end
      ex_idle();
   endtask

   task automatic test_ext_stall();
      int strobes = 0;
      ex_set(30'h44, 2'd1, 32'h0000_0200, 32'h0, 5'd7, 1'b0);
      ext_stall   = 1'b1;
      bus_rdy_    = 1'b0;
      bus_rd_data = 32'hCAFE_F00D;
      #2;
      if (bus_as_ === 1'b0) strobes++;
      tick();
      bus_rdy_    = 1'b1;
      bus_rd_data = 32'h0;
      for (int i = 0; i < 3; i++) begin
         #2;
         if (bus_as_ === 1'b0) strobes++;
         vec++; if (busy !== 1'b0) begin $display("FAIL stl_busy%0d: got %b want 0", i, busy); err++; end
         tick();
         vec++; if (mem_pc !== 30'h38) begin
            $display("FAIL stl_hold%0d: got pc=%h want 38", i, mem_pc); err++;
         end
      end
      ext_stall = 1'b0;
      #2;
      if (bus_as_ === 1'b0) strobes++;
      tick();
      ex_idle();
      vec++; if (mem_out !== 32'hCAFE_F00D || mem_pc !== 30'h44 || mem_dst_addr !== 5'd7) begin
         $display("FAIL stl_out: got out=%h pc=%h dst=%0d want cafef00d/44/7", mem_out, mem_pc, mem_dst_addr);
         err++;
      end
      vec++; if (strobes != 1) begin $display("FAIL stl_strobes: got %0d want 1", strobes); err++; end
   endtask

   task automatic test_flush_access();
      ex_set(30'h50, 2'd1, 32'h0000_0300, 32'h0, 5'd8, 1'b0);
      bus_rdy_ = 1'b1;
      #2;
      vec++; if (busy !== 1'b1) begin $display("FAIL fl_busy: got %b want 1", busy); err++; end
      tick();
      flush = 1'b1;
      #2;
      vec++; if (bus_as_ !== 1'b0 || bus_addr !== 30'hC0) begin
         $display("FAIL fl_keep: got as=%b addr=%h want 0/c0", bus_as_, bus_addr); err++;
      end
      tick();
      vec++; if (mem_en !== 1'b1 || mem_pc !== 30'h44) begin
         $display("FAIL fl_hold: got en=%b pc=%h want 1/44", mem_en, mem_pc); err++;
      end
      bus_rdy_    = 1'b0;
      bus_rd_data = 32'h5555_AAAA;
      #2;
      vec++; if (busy !== 1'b0 || bus_as_ !== 1'b0) begin
         $display("FAIL fl_ack: got busy=%b as=%b want 0/0", busy, bus_as_); err++;
      end
      tick();
      vec++; if (mem_en !== 1'b0 || mem_gpr_we_ !== 1'b1 || mem_exp_code !== 3'd0 || mem_out !== 32'd0) begin
         $display("FAIL fl_memwb: got en=%b we_=%b exp=%0d out=%h want 0/1/0/0",
                  mem_en, mem_gpr_we_, mem_exp_code, mem_out);
         err++;
      end
      flush    = 1'b0;
      bus_rdy_ = 1'b1;
      ex_idle();
   endtask

   task automatic test_reset_in_access();
      ex_set(30'h60, 2'd1, 32'h0000_0008, 32'h0, 5'd2, 1'b0);
      bus_rdy_    = 1'b0;
      bus_rd_data = 32'h1111_2222;
      tick();
      ex_set(30'h64, 2'd1, 32'h0000_0010, 32'h0, 5'd2, 1'b0);
      bus_rdy_ = 1'b1;
      tick();
      reset = 1'b1;
      ex_idle();
      #2;
      vec++; if (bus_as_ !== 1'b0 || mem_en !== 1'b1 || mem_out !== 32'h1111_2222) begin
         $display("FAIL rst_pre: got as=%b en=%b out=%h want 0/1/11112222", bus_as_, mem_en, mem_out);
         err++;
      end
      tick();
      vec++; if (bus_as_ !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL rst_bus: got as=%b busy=%b want 1/0", bus_as_, busy); err++;
      end
      vec++; if (mem_en !== 1'b0 || mem_out !== 32'd0 || mem_gpr_we_ !== 1'b1 || mem_pc !== 30'd0 ||
                 mem_dst_addr !== 5'd0) begin
         $display("FAIL rst_memwb: got en=%b out=%h we_=%b pc=%h dst=%0d want 0/0/1/0/0",
                  mem_en, mem_out, mem_gpr_we_, mem_pc, mem_dst_addr);
         err++;
      end
      reset = 1'b0;
   endtask

   initial begin
      ext_stall   = 1'b0;
      flush       = 1'b0;
      bus_rdy_    = 1'b1;
      bus_rd_data = '0;
      test_reset();
      test_ldw_zero_wait();
      test_stw_wait();
      test_misalign();
      test_ex_exception_and_nop();
      test_ext_stall();
      test_flush_access();
      test_reset_in_access();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
